alu_op_issue: RTL and testbench

- Issue stage that drives the execute-stage ALU.
- Decodes the ALUOp/funct3/funct7 control bundle into the 4-bit ALU Operation code and registers it, together with both operands, toward the ALU.
- Sits between decode and execute, with valid/ready handshakes on both sides.
- Contains a 2-entry skid buffer, so it sustains one op per cycle under backpressure, and supports pipeline flush.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_op_decode.sv | 35 +++
 rtl/alu_op_issue.sv | 140 ++++++++++++++
 tb/tb_alu_op_issue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, ALUOp encodings and the request bundle handed to the ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_EQ  = 4'b1000,
        ALU_ILL = 4'b1111
    } alu_op_e;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    typedef struct packed {
        alu_op_e             Operation;
        logic [DATA_W-1:0]   SrcA;
        logic [DATA_W-1:0]   SrcB;
        logic                illegal;
    } alu_req_t;

    // Occupancy of the issue stage: output register, then output register plus skid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 decoder producing the ALU operation code and an illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic       Funct7_b5,
    output alu_op_e    Operation,
    output logic       illegal
);

    always_comb begin
        Operation = ALU_ADD;
        illegal   = 1'b0;
        case (ALUOp)
            ALUOP_LDST: Operation = ALU_ADD;
            ALUOP_BRANCH: Operation = (Funct3 == F3_BEQ) ? ALU_EQ : ALU_SUB;
            default: begin
                case (Funct3)
                    // Only R-type uses funct7 to pick SUB; I-type 000 is always ADDI.
                    F3_ADDSUB: Operation = (ALUOp == ALUOP_RTYPE && Funct7_b5) ? ALU_SUB : ALU_ADD;
                    F3_AND:    Operation = ALU_AND;
                    F3_OR:     Operation = ALU_OR;
                    F3_XOR:    Operation = ALU_XOR;
                    F3_SLT:    Operation = ALU_SLT;
                    default: begin
                        Operation = ALU_ILL;
                        illegal   = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes the control bundle and registers op+operands toward the ALU through a
// 2-entry skid buffer. Optional saturating illegal-op counter under ALU_ILLEGAL_CNT_EN.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    SrcA_in,
    input  logic [DATA_WIDTH-1:0]    SrcB_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     illegal,
    output logic [1:0]               dbg_state
`ifdef ALU_ILLEGAL_CNT_EN
    ,
    output logic [15:0]              illegal_cnt
`endif
);

    // Handshake: a beat moves when valid && ready on that side in the same cycle; in_ready depends
    // only on registered occupancy, and outputs are held while out_valid && !out_ready.

    alu_op_e                  dec_op;
    logic                     dec_ill;
    logic [OPCODE_LENGTH-1:0] dec_op_w;
    logic                     unused_funct7;

    alu_op_decode u_decode (
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7_b5 (Funct7[5]),
        .Operation (dec_op),
        .illegal   (dec_ill)
    );

    assign dec_op_w      = OPCODE_LENGTH'(dec_op);
    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    occ_e                     state_q, state_d;
    logic                     in_ready_q, out_valid_q;
    logic [OPCODE_LENGTH-1:0] op_q, skid_op_q;
    logic [DATA_WIDTH-1:0]    a_q, b_q, skid_a_q, skid_b_q;
    logic                     ill_q, skid_ill_q;
    logic                     accept, xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (accept) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !xfer)      state_d = OCC_TWO;
                    else if (!accept && xfer) state_d = OCC_EMPTY;
                end
                OCC_TWO:   if (xfer) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ill_q       <= 1'b0;
            skid_op_q   <= '0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != OCC_TWO);
            out_valid_q <= (state_d != OCC_EMPTY);
            if (!flush) begin
                if (state_q == OCC_TWO && xfer) begin
                    op_q  <= skid_op_q;
                    a_q   <= skid_a_q;
                    b_q   <= skid_b_q;
                    ill_q <= skid_ill_q;
                end else if (accept && (state_q == OCC_EMPTY || xfer)) begin
                    op_q  <= dec_op_w;
                    a_q   <= SrcA_in;
                    b_q   <= SrcB_in;
                    ill_q <= dec_ill;
                end else if (accept) begin
                    // Output register is stalled: park the new op in the skid entry.
                    skid_op_q  <= dec_op_w;
                    skid_a_q   <= SrcA_in;
                    skid_b_q   <= SrcB_in;
                    skid_ill_q <= dec_ill;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Operation = op_q;
    assign SrcA      = a_q;
    assign SrcB      = b_q;
    assign illegal   = ill_q;
    assign dbg_state = state_q;

`ifdef ALU_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt_q;

    // A transfer coinciding with flush is dropped, so it is not counted either.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt_q <= '0;
        end else if (xfer && !flush && ill_q && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed steps plus random traffic against a queue-based reference model.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ALUOp = 2'b00;
    logic [2:0]  Funct3 = 3'b000;
    logic [6:0]  Funct7 = 7'b0;
    logic [31:0] SrcA_in = '0;
    logic [31:0] SrcB_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        illegal;
    logic [1:0]  dbg_state;
`ifdef ALU_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .SrcA_in   (SrcA_in),
        .SrcB_in   (SrcB_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .illegal   (illegal),
        .dbg_state (dbg_state)
`ifdef ALU_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] got_q[$];
    logic [15:0] exp_cnt = '0;
    int          tests = 0;
    int          fails = 0;
    int          dut_xfers = 0;

    // Reference decode straight from the opcode table: {illegal, code}.
    function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
        if (aop == 2'b00) return 5'b0_0010;
        if (aop == 2'b01) return (f3 == 3'b000) ? 5'b0_1000 : 5'b0_0100;
        case (f3)
            3'b000:  return (aop == 2'b10 && f7[5]) ? 5'b0_0100 : 5'b0_0010;
            3'b111:  return 5'b0_0000;
            3'b110:  return 5'b0_0001;
            3'b100:  return 5'b0_0011;
            3'b010:  return 5'b0_0101;
            default: return 5'b1_1111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_operation", {28'b0, Operation}, 32'd0);
        chk("rst_srca", SrcA, 32'd0);
        chk("rst_srcb", SrcB, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
    endtask

    task automatic tick();
        ent_t       cur;
        logic [4:0] d;
        logic       xf, ac;
        if (out_valid && out_ready) begin
            dut_xfers++;
            got_q.push_back(SrcA);
        end
        d   = ref_dec(ALUOp, Funct3, Funct7);
        cur = '{op: d[3:0], a: SrcA_in, b: SrcB_in, ill: d[4]};
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_cnt = '0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            xf = (exp_q.size() > 0) && out_ready;
            ac = in_valid && (exp_q.size() < 2);
            if (xf) begin
                if (exp_q[0].ill && exp_cnt != 16'hFFFF) exp_cnt++;
                void'(exp_q.pop_front());
            end
            if (ac) exp_q.push_back(cur);
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        if (exp_q.size() > 0) begin
            chk("operation", {28'b0, Operation}, {28'b0, exp_q[0].op});
            chk("srca", SrcA, exp_q[0].a);
            chk("srcb", SrcB, exp_q[0].b);
            chk("illegal", {31'b0, illegal}, {31'b0, exp_q[0].ill});
        end
`ifdef ALU_ILLEGAL_CNT_EN
        chk("illegal_cnt", {16'b0, illegal_cnt}, {16'b0, exp_cnt});
`endif
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b);
        ALUOp   = aop;
        Funct3  = f3;
        Funct7  = f7;
        SrcA_in = a;
        SrcB_in = b;
    endtask

    task automatic rand_op();
        set_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom_range(0, 127)),
               $urandom, $urandom);
    endtask

    initial begin
        // Reset and reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_zero();

        // R-type SUB
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(2'b10, 3'b000, 7'b0100000, 32'd7, 32'd3);
        tick();
        chk("sub_op", {28'b0, Operation}, 32'h4);
        chk("sub_srca", SrcA, 32'd7);
        chk("sub_srcb", SrcB, 32'd3);

        // Decode sweep
        set_op(2'b11, 3'b000, 7'b0100000, 32'd11, 32'd12);
        tick();
        chk("itype_add_op", {28'b0, Operation}, 32'h2);
        set_op(2'b01, 3'b000, 7'b0, 32'd13, 32'd14);
        tick();
        chk("beq_op", {28'b0, Operation}, 32'h8);
        set_op(2'b01, 3'b001, 7'b0, 32'd15, 32'd16);
        tick();
        chk("bne_op", {28'b0, Operation}, 32'h4);
        set_op(2'b10, 3'b001, 7'b0, 32'd17, 32'd18);
        tick();
        chk("ill_op", {28'b0, Operation}, 32'hF);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            set_op(2'b10, 3'(i), 7'b0, 32'(i), 32'(i + 100));
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: A, B, C with the ALU stalled
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(2'b10, 3'b111, 7'b0, 32'hA, 32'h1);
        tick();
        set_op(2'b10, 3'b110, 7'b0, 32'hB, 32'h2);
        tick();
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        set_op(2'b10, 3'b100, 7'b0, 32'hC, 32'h3);
        tick();
        chk("bp_hold_a", SrcA, 32'hA);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("bp_first", got_q[0], 32'hA);
            chk("bp_second", got_q[1], 32'hB);
            chk("bp_third", got_q[2], 32'hC);
        end

        // Full throughput
        dut_xfers = 0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_op();
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("throughput", 32'(dut_xfers), 32'd10);

        // Flush while TWO with an op offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_op();
        tick();
        rand_op();
        tick();
        set_op(2'b00, 3'b000, 7'b0, 32'hDEAD, 32'hBEEF);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        tick();

        // Reset mid-stream
        in_valid = 1'b1;
        rand_op();
        tick();
        rand_op();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk_zero();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            rand_op();
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

`ifdef ALU_ILLEGAL_CNT_EN
        // Illegal-op counter: three delivered, one flushed
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(2'b10, 3'b001, 7'b0, 32'd1, 32'd1);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("illegal_cnt_final", {16'b0, illegal_cnt}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
